// File: rtl/johnson_decoder.sv
`timescale 1ns/1ps
// Johnson-code receiver.
// Decodes each valid sample of a Johnson-coded bus to its phase index.
// Flags codes that are not legal Johnson codes, and flags legal codes that
// do not follow the previous legal sample. A three-state lock machine
// tracks runs of correct successor transitions. All outputs are registered.
module johnson_decoder #(
    parameter int N        = 4,
    parameter int LOCK_CNT = 3,
    parameter int IW       = $clog2(2 * N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  code_in,
    input  logic          code_valid,
    input  logic          err_clr,
    output logic [IW-1:0] index,
    output logic          index_valid,
    output logic          illegal,
    output logic          step_err,
    output logic          locked,
    output logic [7:0]    err_count
);

    localparam int SEQ_LEN = 2 * N;
    localparam int RW      = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        UNLOCKED,
        ACQUIRE,
        LOCKED
    } lock_state_e;

    // Number of ones in a code word.
    function automatic int popcount(input logic [N-1:0] c);
        int p;
        p = 0;
        for (int i = 0; i < N; i++) begin
            if (c[i]) p++;
        end
        return p;
    endfunction

    // A legal code is a thermometer packed against the MSB (1..10..0),
    // or a thermometer packed against the LSB with the MSB clear (0..01..1).
    function automatic logic is_legal(input logic [N-1:0] c);
        int          p;
        logic [N-1:0] msb_form;
        logic [N-1:0] lsb_form;
        p = popcount(c);
        for (int i = 0; i < N; i++) begin
            msb_form[i] = (i >= N - p);
            lsb_form[i] = (i < p);
        end
        return (c == msb_form) || (!c[N-1] && (c == lsb_form));
    endfunction

    lock_state_e   state_q, state_d;
    logic [RW-1:0] run_q, run_d;
    logic          ref_valid_q, ref_valid_d;
    logic [IW-1:0] ref_idx_q, ref_idx_d;
    logic [IW-1:0] index_q, index_d;
    logic          index_valid_q, index_valid_d;
    logic          illegal_q, illegal_d;
    logic          step_err_q, step_err_d;
    logic [7:0]    err_count_q, err_count_d;

    logic          legal;
    int            pop;
    logic [IW-1:0] dec_idx;
    logic [IW-1:0] exp_idx;
    logic          is_succ;
    logic [RW-1:0] run_inc;

    // Decode the sample, evaluate the successor rule and compute next state.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        run_d         = run_q;
        ref_valid_d   = ref_valid_q;
        ref_idx_d     = ref_idx_q;
        index_d       = index_q;
        index_valid_d = 1'b0;
        illegal_d     = 1'b0;
        step_err_d    = 1'b0;
        err_count_d   = err_count_q;

        pop     = popcount(code_in);
        legal   = is_legal(code_in);
        dec_idx = (code_in[N-1] || (code_in == '0)) ? IW'(pop) : IW'(SEQ_LEN - pop);
        exp_idx = (ref_idx_q == IW'(SEQ_LEN - 1)) ? '0 : ref_idx_q + IW'(1);
        is_succ = ref_valid_q && (dec_idx == exp_idx);
        run_inc = run_q + RW'(1);

        if (code_valid) begin
            if (!legal) begin
                // Illegal code: drop the reference and lose lock.
                illegal_d   = 1'b1;
                index_d     = '0;
                ref_valid_d = 1'b0;
                state_d     = UNLOCKED;
                run_d       = '0;
            end else begin
                index_d       = dec_idx;
                index_valid_d = 1'b1;
                ref_idx_d     = dec_idx;
                ref_valid_d   = 1'b1;
                step_err_d    = ref_valid_q && !is_succ;
                case (state_q)
                    UNLOCKED: begin
                        state_d = ACQUIRE;
                        run_d   = '0;
                    end
                    ACQUIRE: begin
                        if (is_succ) begin
                            run_d = run_inc;
                            if (run_inc == RW'(LOCK_CNT)) state_d = LOCKED;
                        end else begin
                            run_d = '0;
                        end
                    end
                    LOCKED: begin
                        if (!is_succ) begin
                            state_d = ACQUIRE;
                            run_d   = '0;
                        end
                    end
                    default: begin
                        state_d = UNLOCKED;
                        run_d   = '0;
                    end
                endcase
            end
        end

        // Clear wins over a coincident error; otherwise count up to 255.
        if (err_clr) begin
            err_count_d = '0;
        end else if (code_valid && (illegal_d || step_err_d) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values and simulation matches the synthesized flops.
        if (reset) begin
            state_q       <= UNLOCKED;
            run_q         <= '0;
            ref_valid_q   <= 1'b0;
            ref_idx_q     <= '0;
            index_q       <= '0;
            index_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            step_err_q    <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            run_q         <= run_d;
            ref_valid_q   <= ref_valid_d;
            ref_idx_q     <= ref_idx_d;
            index_q       <= index_d;
            index_valid_q <= index_valid_d;
            illegal_q     <= illegal_d;
            step_err_q    <= step_err_d;
            err_count_q   <= err_count_d;
        end
    end

    assign index       = index_q;
    assign index_valid = index_valid_q;
    assign illegal     = illegal_q;
    assign step_err    = step_err_q;
    assign locked      = (state_q == LOCKED);
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_johnson_decoder.sv
`timescale 1ns/1ps
// Self-checking bench for johnson_decoder (N=4, LOCK_CNT=3).
// The reference model walks a table of the counter's sequence and tracks
// a streak of correct successor transitions since the last reference loss.
module tb_johnson_decoder;

    localparam int N        = 4;
    localparam int LOCK_CNT = 3;
    localparam int SEQ      = 2 * N;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] code_in;
    logic       code_valid;
    logic       err_clr;
    logic [2:0] index;
    logic       index_valid;
    logic       illegal;
    logic       step_err;
    logic       locked;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    johnson_decoder #(.N(N), .LOCK_CNT(LOCK_CNT)) dut (
        .clk        (clk),
        .reset      (reset),
        .code_in    (code_in),
        .code_valid (code_valid),
        .err_clr    (err_clr),
        .index      (index),
        .index_valid(index_valid),
        .illegal    (illegal),
        .step_err   (step_err),
        .locked     (locked),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    wire [14:0] dut_vec = {index, index_valid, illegal, step_err, locked, err_count};

    // ---------------- reference model ----------------
    logic [3:0] jseq [SEQ];
    int m_ref;
    bit m_ref_ok;
    int m_streak;
    int m_index;
    bit m_iv, m_ill, m_step;
    int m_err;

    function automatic int lookup(input logic [3:0] c);
        for (int i = 0; i < SEQ; i++) if (jseq[i] == c) return i;
        return -1;
    endfunction

    function bit m_locked();
        return m_streak >= LOCK_CNT;
    endfunction

    function logic [14:0] exp_vec();
        return {3'(m_index), m_iv, m_ill, m_step, m_locked(), 8'(m_err)};
    endfunction

    task automatic model_reset();
        m_ref = 0; m_ref_ok = 0; m_streak = -1;
        m_index = 0; m_iv = 0; m_ill = 0; m_step = 0; m_err = 0;
    endtask

    task automatic model_step(input logic [3:0] c, input bit v, input bit clr);
        bit ev;
        int idx;
        ev = 0;
        if (v) begin
            idx = lookup(c);
            if (idx < 0) begin
                m_ill = 1; m_step = 0; m_iv = 0; m_index = 0;
                m_ref_ok = 0; m_streak = -1; ev = 1;
            end else begin
                m_ill = 0; m_iv = 1; m_index = idx;
                if (m_ref_ok) begin
                    m_step   = (idx != (m_ref + 1) % SEQ);
                    m_streak = m_step ? 0 : m_streak + 1;
                end else begin
                    m_step   = 0;
                    m_streak = 0;
                end
                m_ref = idx; m_ref_ok = 1; ev = m_step;
            end
        end else begin
            m_ill = 0; m_iv = 0; m_step = 0;
        end
        if (clr) m_err = 0;
        else if (ev && m_err < 255) m_err++;
    endtask

    // Apply one sample on a clock edge and advance the model with it.
    task automatic drive(input logic [3:0] c, input bit v, input bit clr);
        @(negedge clk);
        code_in = c; code_valid = v; err_clr = clr;
        @(posedge clk);
        model_step(c, v, clr);
        #1;
    endtask

    function automatic logic [3:0] random_illegal();
        logic [3:0] c;
        do c = 4'($urandom_range(0, 15)); while (lookup(c) >= 0);
        return c;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; code_in = '0; code_valid = 1'b0; err_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_vec !== 15'd0) begin
            errors++;
            $display("FAIL reset_state: got %b want %b", dut_vec, 15'd0);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_clean_stream();
        for (int i = 0; i <= SEQ; i++) begin
            drive(jseq[i % SEQ], 1, 0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL clean_vec[%0d]: got %b want %b", i, dut_vec, exp_vec());
            end
            checks++;
            if (index !== 3'(i % SEQ) || step_err !== 1'b0 || locked !== (i >= 3)) begin
                errors++;
                $display("FAIL clean_idx[%0d]: got idx=%0d step=%b lock=%b want idx=%0d step=0 lock=%b",
                         i, index, step_err, locked, i % SEQ, (i >= 3));
            end
        end
    endtask

    task automatic test_illegal_locked();
        drive(4'b1010, 1, 0);
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL illegal_vec: got %b want %b", dut_vec, exp_vec());
        end
        checks++;
        if (illegal !== 1'b1 || index !== 3'd0 || locked !== 1'b0 || err_count !== 8'd1) begin
            errors++;
            $display("FAIL illegal_flags: got ill=%b idx=%0d lock=%b err=%0d want ill=1 idx=0 lock=0 err=1",
                     illegal, index, locked, err_count);
        end
        drive(4'b0011, 1, 0);
        checks++;
        if (dut_vec !== exp_vec() || step_err !== 1'b0 || index !== 3'd6) begin
            errors++;
            $display("FAIL illegal_after: got %b want %b (idx 6, no step_err)", dut_vec, exp_vec());
        end
    endtask

    task automatic test_skip();
        logic [3:0] pre [3];
        logic [3:0] post [3];
        pre  = '{4'b0001, 4'b0000, 4'b1000};
        post = '{4'b0111, 4'b0011, 4'b0001};
        foreach (pre[i]) begin
            drive(pre[i], 1, 0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL skip_pre[%0d]: got %b want %b", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL skip_lock_before: got %b want 1", locked);
        end
        drive(4'b1100, 1, 0);
        drive(4'b1111, 1, 0);
        checks++;
        if (dut_vec !== exp_vec() || step_err !== 1'b1 || index !== 3'd4 || locked !== 1'b0) begin
            errors++;
            $display("FAIL skip_step: got step=%b idx=%0d lock=%b want step=1 idx=4 lock=0",
                     step_err, index, locked);
        end
        foreach (post[i]) begin
            drive(post[i], 1, 0);
            checks++;
            if (dut_vec !== exp_vec() || locked !== (i == 2)) begin
                errors++;
                $display("FAIL skip_relock[%0d]: got %b want %b lock=%b", i, dut_vec, exp_vec(), (i == 2));
            end
        end
    endtask

    task automatic test_gap_wrap();
        for (int i = 0; i < 5; i++) begin
            drive(4'($urandom_range(0, 15)), 0, 0);
            checks++;
            if (dut_vec !== exp_vec() || index_valid !== 1'b0 || index !== 3'd7) begin
                errors++;
                $display("FAIL gap[%0d]: got %b want %b (iv=0, idx held 7)", i, dut_vec, exp_vec());
            end
        end
        drive(4'b0000, 1, 0);
        checks++;
        if (dut_vec !== exp_vec() || step_err !== 1'b0 || index !== 3'd0 || index_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap: got step=%b idx=%0d iv=%b want step=0 idx=0 iv=1", step_err, index, index_valid);
        end
    endtask

    task automatic test_saturation();
        int bad;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            drive(random_illegal(), 1, 0);
            if (dut_vec !== exp_vec()) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL sat_stream: %0d mismatching cycles, want 0", bad);
        end
        checks++;
        if (err_count !== 8'd255) begin
            errors++;
            $display("FAIL sat_value: got %0d want 255", err_count);
        end
        drive(4'b1010, 1, 1);
        checks++;
        if (dut_vec !== exp_vec() || err_count !== 8'd0 || illegal !== 1'b1) begin
            errors++;
            $display("FAIL sat_clear: got err=%0d ill=%b want err=0 ill=1", err_count, illegal);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) drive(jseq[i], 1, 0);
        checks++;
        if (locked !== 1'b1 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL areset_prelock: got %b want %b", dut_vec, exp_vec());
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (dut_vec !== 15'd0) begin
            errors++;
            $display("FAIL areset_immediate: got %b want %b", dut_vec, 15'd0);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0; code_valid = 1'b0;
        drive(4'b1110, 1, 0);
        checks++;
        if (dut_vec !== exp_vec() || index !== 3'd3 || step_err !== 1'b0) begin
            errors++;
            $display("FAIL areset_first: got idx=%0d step=%b want idx=3 step=0", index, step_err);
        end
    endtask

    task automatic test_random();
        int r;
        logic [3:0] c;
        bit v, clr;
        for (int i = 0; i < 500; i++) begin
            r   = $urandom_range(0, 99);
            v   = (r >= 10);
            clr = ($urandom_range(0, 49) == 0);
            if (r < 70 && m_ref_ok) c = jseq[(m_ref + 1) % SEQ];
            else if (r < 88)        c = jseq[$urandom_range(0, SEQ - 1)];
            else                    c = 4'($urandom_range(0, 15));
            drive(c, v, clr);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random[%0d] code=%b v=%b clr=%b: got %b want %b",
                         i, c, v, clr, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        logic [3:0] q;
        q = '0;
        for (int i = 0; i < SEQ; i++) begin
            jseq[i] = q;
            q = {~q[0], q[3:1]};
        end
        test_reset();
        test_clean_stream();
        test_illegal_locked();
        test_skip();
        test_gap_wrap();
        test_saturation();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
